// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: single-issue sequencer for the ARM-style data-processing ALU.
// Latches one request, evaluates its condition code against the held NZCV
// flags, drives the ALU for one cycle, updates the flags and presents
// non-test results on a writeback handshake.
module alu_seq_ctrl #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // Request from decode
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_cond,
    input  logic [3:0]    req_op,
    input  logic          req_s,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    input  logic [RW-1:0] req_rd,
    // Combinational ALU
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          alu_c,
    input  logic          alu_v,
    // Writeback toward the register file
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    // Architectural flags
    output logic [3:0]    flags,
    input  logic          flag_wr,
    input  logic [3:0]    flag_wr_data,
    output logic          skipped
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    op_q, cond_q;
    logic          s_q;
    logic [DW-1:0] a_q, b_q;
    logic [RW-1:0] rd_q;
    logic [3:0]    flags_q;
    logic [DW-1:0] wb_data_q;
    logic [RW-1:0] wb_rd_q;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;
    logic is_test, is_arith;
    logic exec_flag_upd;
    logic [3:0] exec_flags;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // tst/teq/cmp/cmn only set flags; arithmetic ops also produce V.
    assign is_test  = (op_q[3:2] == 2'b10);
    assign is_arith = (!op_q[3] && (op_q[2:1] != 2'b00)) || (op_q[3:1] == 3'b101);

    // ARM condition evaluation on the flags held at EXEC.
    always_comb begin
        cond_pass = 1'b0;
        case (cond_q)
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !flag_c || flag_z;
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = flag_z || (flag_n != flag_v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign exec_flag_upd = (state_q == EXEC) && cond_pass && (s_q || is_test);
    assign exec_flags    = {alu_n, alu_z, alu_c, is_arith ? alu_v : flag_v};

    // Next-state logic for the IDLE/EXEC/WB sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = EXEC;
            EXEC:    state_d = (cond_pass && !is_test) ? WB : IDLE;
            WB:      if (wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and writeback capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cond_q    <= '0;
            s_q       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                op_q   <= req_op;
                cond_q <= req_cond;
                s_q    <= req_s;
                a_q    <= req_a;
                b_q    <= req_b;
                rd_q   <= req_rd;
            end
            if (state_q == EXEC && cond_pass && !is_test) begin
                wb_data_q <= alu_out;
                wb_rd_q   <= rd_q;
            end
        end
    end

    // Flag register: an EXEC update takes priority over a direct write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (exec_flag_upd) begin
            flags_q <= exec_flags;
        end else if (flag_wr) begin
            flags_q <= flag_wr_data;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign wb_valid  = (state_q == WB);
    assign skipped   = (state_q == EXEC) && !cond_pass;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_cin   = flag_c;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ARM-style ALU attached.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_s;
    logic [3:0]  req_cond, req_op;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_rd;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_cin, alu_n, alu_z, alu_c, alu_v;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags;
    logic        flag_wr;
    logic [3:0]  flag_wr_data;
    logic        skipped;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl #(.DW(32), .RW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
        .req_op(req_op), .req_s(req_s), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags(flags), .flag_wr(flag_wr), .flag_wr_data(flag_wr_data), .skipped(skipped)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: logical ops pass cin through as C (no shifter here).
    logic [31:0] x, y;
    logic        ci, arith;
    logic [32:0] sum;
    always_comb begin
        x = alu_a; y = alu_b; ci = 1'b0; arith = 1'b1;
        alu_out = '0;
        case (alu_op)
            4'h2, 4'hA: begin y = ~alu_b; ci = 1'b1; end
            4'h3:       begin x = alu_b; y = ~alu_a; ci = 1'b1; end
            4'h4, 4'hB: ci = 1'b0;
            4'h5:       ci = alu_cin;
            4'h6:       begin y = ~alu_b; ci = alu_cin; end
            4'h7:       begin x = alu_b; y = ~alu_a; ci = alu_cin; end
            default:    arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        if (arith) alu_out = sum[31:0];
        else begin
            case (alu_op)
                4'h0, 4'h8: alu_out = alu_a & alu_b;
                4'h1, 4'h9: alu_out = alu_a ^ alu_b;
                4'hC:       alu_out = alu_a | alu_b;
                4'hD:       alu_out = alu_b;
                4'hE:       alu_out = alu_a & ~alu_b;
                default:    alu_out = ~alu_b;
            endcase
        end
        alu_n = alu_out[31];
        alu_z = (alu_out == 32'd0);
        alu_c = arith ? sum[32] : alu_cin;
        alu_v = arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
        req_valid = 1'b1; req_cond = cond; req_op = op; req_s = s;
        req_a = a; req_b = b; req_rd = rd;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_cond = '0; req_op = '0; req_s = 1'b0;
        req_a = '0; req_b = '0; req_rd = '0; wb_ready = 1'b1;
        flag_wr = 1'b0; flag_wr_data = '0;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_skipped", 32'(skipped), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // ADD S=1 AL
        issue(4'hE, 4'h4, 1'b1, 32'h01234561, 32'h8edcba91, 4'd5);
        check("add_exec_ready", 32'(req_ready), 32'd0);
        check("add_alu_a", alu_a, 32'h01234561);
        check("add_alu_b", alu_b, 32'h8edcba91);
        check("add_alu_op", 32'(alu_op), 32'h4);
        check("add_no_wb_in_exec", 32'(wb_valid), 32'd0);
        tick();
        check("add_wb_valid", 32'(wb_valid), 32'd1);
        check("add_wb_data", wb_data, 32'h8ffffff2);
        check("add_wb_rd", 32'(wb_rd), 32'd5);
        check("add_flags", 32'(flags), 32'h8);
        tick();
        check("add_idle_ready", 32'(req_ready), 32'd1);
        check("add_wb_drop", 32'(wb_valid), 32'd0);

        // CMN S=0: test op, flags only, two-cycle turnaround
        issue(4'hE, 4'hB, 1'b0, 32'hffff0000, 32'h80000000, 4'd6);
        tick();
        check("cmn_no_wb", 32'(wb_valid), 32'd0);
        check("cmn_flags", 32'(flags), 32'h3);
        check("cmn_ready", 32'(req_ready), 32'd1);

        // Direct flag write, then ADC uses held C as carry-in
        flag_wr = 1'b1; flag_wr_data = 4'b0010;
        tick();
        flag_wr = 1'b0;
        check("flag_wr_idle", 32'(flags), 32'h2);
        issue(4'hE, 4'h5, 1'b1, 32'hffffffff, 32'h00000000, 4'd1);
        check("adc_cin", 32'(alu_cin), 32'd1);
        tick();
        check("adc_wb_data", wb_data, 32'h00000000);
        check("adc_flags", 32'(flags), 32'h6);
        tick();

        // EQ MOV passes on Z=1; logical op keeps V
        issue(4'h0, 4'hD, 1'b1, 32'h0, 32'h80000000, 4'd2);
        check("mov_not_skipped", 32'(skipped), 32'd0);
        tick();
        check("mov_wb_valid", 32'(wb_valid), 32'd1);
        check("mov_wb_data", wb_data, 32'h80000000);
        check("mov_flags", 32'(flags), 32'hA);
        tick();

        // EQ ADD with Z=0 is skipped
        issue(4'h0, 4'h4, 1'b1, 32'h1, 32'h1, 4'd3);
        check("eq_skipped", 32'(skipped), 32'd1);
        tick();
        check("eq_skip_pulse_end", 32'(skipped), 32'd0);
        check("eq_skip_no_wb", 32'(wb_valid), 32'd0);
        check("eq_skip_flags", 32'(flags), 32'hA);
        check("eq_skip_ready", 32'(req_ready), 32'd1);

        // Condition 1111 never executes
        issue(4'hF, 4'hD, 1'b1, 32'h0, 32'h0, 4'd3);
        check("nv_skipped", 32'(skipped), 32'd1);
        tick();
        check("nv_no_wb", 32'(wb_valid), 32'd0);
        check("nv_flags", 32'(flags), 32'hA);

        // Writeback stall: outputs hold, new requests ignored
        wb_ready = 1'b0;
        issue(4'hE, 4'h4, 1'b0, 32'h1, 32'h2, 4'd7);
        tick();
        req_valid = 1'b1; req_cond = 4'hE; req_op = 4'hD; req_s = 1'b1;
        req_a = 32'h9; req_b = 32'h0; req_rd = 4'd9;
        for (int i = 0; i < 3; i++) begin
            check("stall_wb_valid", 32'(wb_valid), 32'd1);
            check("stall_wb_data", wb_data, 32'h3);
            check("stall_wb_rd", 32'(wb_rd), 32'd7);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        check("stall_release_ready", 32'(req_ready), 32'd1);
        check("stall_release_wb", 32'(wb_valid), 32'd0);
        tick();
        check("ignored_req_ready", 32'(req_ready), 32'd1);
        check("ignored_req_flags", 32'(flags), 32'hA);

        // flag_wr collides with EXEC update: EXEC wins
        issue(4'hE, 4'h4, 1'b1, 32'h1, 32'h1, 4'd4);
        flag_wr = 1'b1; flag_wr_data = 4'hF;
        tick();
        check("collide_flags", 32'(flags), 32'h0);
        check("collide_wb_data", wb_data, 32'h2);
        // flag_wr honoured in WB
        flag_wr_data = 4'h5;
        tick();
        flag_wr = 1'b0;
        check("flag_wr_wb", 32'(flags), 32'h5);

        // Reset while in WB abandons the result immediately
        wb_ready = 1'b0;
        issue(4'hE, 4'h4, 1'b1, 32'h7, 32'h8, 4'd8);
        tick();
        check("pre_rst_wb_valid", 32'(wb_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_wb_valid", 32'(wb_valid), 32'd0);
        check("midrst_flags", 32'(flags), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_skipped", 32'(skipped), 32'd0);
        check("midrst_wb_data", wb_data, 32'h0);
        tick();
        rst_n = 1'b1;
        wb_ready = 1'b1;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
